// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - sticky rising-edge request capture with masked highest-index valid/ack presentation
//
// Optional feature macro: IRQ_REQ_SYNC_EN
//   When defined, req_in passes through a 2-flop synchronizer before edge detection.

module irq_pending_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ack,
  output logic [N-1:0]     pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     req_src;
  logic [N-1:0]     req_q;
  logic [N-1:0]     req_edge;
  logic [N-1:0]     clr;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] sel;
  logic             load_idx;
  logic             take;

`ifdef IRQ_REQ_SYNC_EN
  logic [N-1:0] sync_1;
  logic [N-1:0] sync_2;

  // Two-flop synchronizer; resets to ones so lines held high through reset do not look like fresh edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= req_in;
      sync_2 <= sync_1;
    end
  end

  assign req_src = sync_2;
`else
  assign req_src = req_in;
`endif

  // A line counts only on its 0->1 transition relative to the previous cycle.
  assign req_edge = req_src & ~req_q;

  // Only an ack while presenting retires anything; a stray ack in IDLE is ignored.
  assign take = (state == PRESENT) && irq_ack;
  assign clr  = take ? (ONE_HOT0 << irq_idx) : '0;

  // Masked lines still accumulate pending bits; the mask only gates presentation.
  assign cand = pending & mask;

  // Edge history and sticky pending bits; a same-cycle set beats the ack clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '1;
      pending <= '0;
    end else begin
      req_q   <= req_src;
      pending <= (pending & ~clr) | req_edge;
    end
  end

  // Priority encode: higher index wins, so later iterations overwrite lower ones.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        sel = IDX_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: latch a winner in IDLE, then hold it frozen until the consumer acks.
  always_comb begin
    state_nxt = state;
    load_idx  = 1'b0;
    case (state)
      IDLE: begin
        if (cand != '0) begin
          load_idx  = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Presented index is captured once on entry to PRESENT so mask changes and new edges cannot pre-empt it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_idx <= '0;
    end else if (load_idx) begin
      irq_idx <= sel;
    end
  end

  assign irq_valid = (state == PRESENT);

endmodule
